alu_operand_stage: RTL

- Upstream/downstream wrapper stage for the 16-bit ALU.
- Holds an 8x16 register file and accepts one instruction at a time over a valid/ready handshake.
- Registers the two operands and op onto the ALU inputs, then writes the ALU's combinational result back into the destination register.
- Also provides an external load port and a debug read port for initialisation and checking.

---
 rtl/alu_operand_stage.sv | 104 ++++++++++
 1 files changed

// File: rtl/alu_operand_stage.sv
// Operand/writeback wrapper around a 16-bit combinational ALU: 8x16 regfile, one instruction per 3 cycles.
// Optional ALU_STAGE_ZERO_REG_EN: register 0 is hardwired to zero.
module alu_operand_stage #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_op,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [REG_AW-1:0] in_rs1,
  input  logic [REG_AW-1:0] in_rs2,
  output logic [DATA_W-1:0] ALU_in1,
  output logic [DATA_W-1:0] ALU_in2,
  output logic [1:0]        ALU_op,
  input  logic [DATA_W-1:0] ALU_out,
  input  logic              ld_en,
  input  logic [REG_AW-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic              wb_valid,
  output logic              err_op
);

  localparam int NREG = 1 << REG_AW;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_WB   = 2'd2;

`ifdef ALU_STAGE_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  logic [1:0]        state;
  logic [DATA_W-1:0] regs [NREG];
  logic [REG_AW-1:0] rd_q;

  logic              handshake;
  logic              reserved;
  logic              accept;
  logic              wb_we;
  logic              ld_we;
  logic [DATA_W-1:0] rs1_val;
  logic [DATA_W-1:0] rs2_val;

  // Loads win over instructions in IDLE, so a pending load hides in_ready.
  assign in_ready  = (state == S_IDLE) && !ld_en;
  assign handshake = in_valid && in_ready;
  assign reserved  = (in_op == 2'b11);
  assign accept    = handshake && !reserved;

  assign wb_we = (state == S_WB) && !(ZERO_REG && (rd_q == '0));
  assign ld_we = (state == S_IDLE) && ld_en && !(ZERO_REG && (ld_addr == '0));

  assign rs1_val  = (ZERO_REG && (in_rs1 == '0))   ? '0 : regs[in_rs1];
  assign rs2_val  = (ZERO_REG && (in_rs2 == '0))   ? '0 : regs[in_rs2];
  assign dbg_data = (ZERO_REG && (dbg_addr == '0)) ? '0 : regs[dbg_addr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wb_we) begin
      regs[rd_q] <= ALU_out;
    end else if (ld_we) begin
      regs[ld_addr] <= ld_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      ALU_in1  <= '0;
      ALU_in2  <= '0;
      ALU_op   <= '0;
      rd_q     <= '0;
      wb_valid <= 1'b0;
      err_op   <= 1'b0;
    end else begin
      wb_valid <= (state == S_WB);
      err_op   <= handshake && reserved;
      case (state)
        S_IDLE: begin
          if (accept) begin
            ALU_in1 <= rs1_val;
            ALU_in2 <= rs2_val;
            ALU_op  <= in_op;
            rd_q    <= in_rd;
            state   <= S_EXEC;
          end
        end
        S_EXEC:  state <= S_WB;
        S_WB:    state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
